// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one-cycle pipeline stage register with ready/valid handshake
// Optional second (skid) entry enabled by defining PIPE_STAGE_SKID_EN; with the skid
// entry in_ready comes only from registered state, otherwise it passes out_ready through.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 96,
    parameter int                 CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ONE   = 1'b1
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              load_head;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;

`ifdef PIPE_STAGE_SKID_EN
    logic              load_skid;
    logic              promote;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
`endif

    // Handshake signals: the head entry is visible whenever the stage is non-empty.
    always_comb begin
        out_valid = (state != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        // Registered-only ready; reset gating keeps upstream off while the stage is held in reset.
        in_ready  = !reset && (state != ST_TWO);
`else
        // Single entry: can accept when empty or when the head leaves this cycle.
        in_ready  = !reset && ((state == ST_EMPTY) || out_ready);
`endif
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_ctrl  = out_valid ? head_ctrl : NOP_CTRL;
        out_data  = head_data;
    end

    // Next-state and datapath load decisions; flush wins over everything.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_skid = 1'b0;
        promote   = 1'b0;
`endif
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_head = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_fire) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
`endif
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_TWO: begin
                if (out_fire) begin
                    state_nxt = ST_ONE;
                    promote   = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
            load_head = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            load_skid = 1'b0;
            promote   = 1'b0;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head entry: loaded from input, or from the skid entry when it is promoted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ctrl <= NOP_CTRL;
            head_data <= '0;
        end else if (load_head) begin
            head_ctrl <= in_ctrl;
            head_data <= in_data;
`ifdef PIPE_STAGE_SKID_EN
        end else if (promote) begin
            head_ctrl <= skid_ctrl;
            head_data <= skid_data;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry: captures the input that arrives while the head is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end
`endif

    // Saturating backpressure counter; deliberately untouched by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (both build variants)
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [CTRL_W+DATA_W-1:0] sb_q[$];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(8'h00)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int i);
        return {32'(i), 32'hCAFE_0000, 32'(i) ^ 32'h5A5A_5A5A};
    endfunction

    task automatic offer(input int i);
        in_valid = 1'b1;
        in_ctrl  = 8'(i + 16);
        in_data  = mk_data(i);
    endtask

    // One clock: observe handshakes mid-cycle, update scoreboard, end 1 time unit after the edge.
    task automatic step();
        logic in_f, out_f;
        logic [CTRL_W+DATA_W-1:0] e;
        @(negedge clk);
        in_f  = in_valid && in_ready;
        out_f = out_valid && out_ready;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_f) begin
                chk("sb_depth", DATA_W'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_data", out_data, e[DATA_W-1:0]);
                    chk("sb_ctrl", DATA_W'(out_ctrl), DATA_W'(e[CTRL_W+DATA_W-1:DATA_W]));
                end
            end
            if (in_f) sb_q.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", DATA_W'(out_valid), 0);
        chk("rst_in_ready", DATA_W'(in_ready), 0);
        chk("rst_out_ctrl", DATA_W'(out_ctrl), 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;

        // Streaming: one-cycle latency, no bubbles.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            step();
            chk("stream_valid", DATA_W'(out_valid), 1);
            chk("stream_data", out_data, mk_data(i));
        end
        in_valid = 1'b0;
        step();
        chk("idle_valid", DATA_W'(out_valid), 0);
        chk("idle_nop", DATA_W'(out_ctrl), 0);
        chk("idle_hold", out_data, mk_data(8));
        chk("stream_stall", DATA_W'(stall_cnt), 0);

        // Backpressure.
        out_ready = 1'b0;
        offer(20);
        step();
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_one_ready", DATA_W'(in_ready), 1);
        offer(21);
        step();
        chk("bp_two_ready", DATA_W'(in_ready), 0);
        in_valid = 1'b0;
        repeat (2) step();
        chk("bp_stall3", DATA_W'(stall_cnt), 3);
        out_ready = 1'b1;
        step();
        chk("bp_promote", out_data, mk_data(21));
        step();
        chk("bp_empty", DATA_W'(out_valid), 0);
`else
        chk("bp_ready0", DATA_W'(in_ready), 0);
        offer(22);
        repeat (3) step();
        chk("bp_stall3", DATA_W'(stall_cnt), 3);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_pass", DATA_W'(in_ready), 1);
        step();
        chk("bp_replace", out_data, mk_data(22));
        in_valid = 1'b0;
        step();
        chk("bp_empty", DATA_W'(out_valid), 0);
`endif

        // Flush from ONE with an acceptable same-cycle input.
        out_ready = 1'b0;
        offer(30);
        step();
        out_ready = 1'b1;
        offer(31);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", DATA_W'(out_valid), 0);
        chk("fl1_nop", DATA_W'(out_ctrl), 0);
        chk("fl1_stall", DATA_W'(stall_cnt), 3);
        repeat (2) step();
        chk("fl1_gone", DATA_W'(out_valid), 0);
`ifdef PIPE_STAGE_SKID_EN
        // Flush from TWO.
        out_ready = 1'b0;
        offer(40);
        step();
        offer(41);
        step();
        offer(42);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid", DATA_W'(out_valid), 0);
        chk("fl2_nop", DATA_W'(out_ctrl), 0);
        chk("fl2_stall", DATA_W'(stall_cnt), 4);
        repeat (2) step();
        chk("fl2_gone", DATA_W'(out_valid), 0);
`endif

        // Saturation.
        out_ready = 1'b0;
        offer(50);
        step();
        in_valid = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_max", DATA_W'(stall_cnt), 16'hFFFF);
        step();
        chk("sat_hold", DATA_W'(stall_cnt), 16'hFFFF);

        // Asynchronous reset mid-cycle while holding an entry and offering another.
        offer(60);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", DATA_W'(out_valid), 0);
        chk("arst_nop", DATA_W'(out_ctrl), 0);
        chk("arst_data", out_data, 0);
        chk("arst_stall", DATA_W'(stall_cnt), 0);
        chk("arst_ready", DATA_W'(in_ready), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First transfer after reset behaves as from EMPTY.
        out_ready = 1'b1;
        offer(70);
        step();
        chk("post_valid", DATA_W'(out_valid), 1);
        chk("post_data", out_data, mk_data(70));
        in_valid = 1'b0;
        step();
        chk("sb_drained", DATA_W'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
